ibex_cheri_scr_file: RTL and testbench
======================================

IBEX_CHERI_SCR_FILE -- requirements
Module: ibex_cheri_scr_file

Interface
REQ-001 SHALL have parameter CapWidth, default 64: capability register width in bits.
REQ-002 SHALL have parameter ImplUScr, default 0: implement U-mode SCRs 0x04-0x07.
REQ-003 SHALL have parameter ImplSScr, default 0: implement S-mode SCRs 0x0C-0x0F.
REQ-004 SHALL have parameter RootCap, default all-ones [CapWidth-1:0]: reset value of DDC and MTCC.
REQ-005 SHALL have port clk_i  in  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports scr_req_i in 1 (request valid), scr_op_i in 2 (scr_op_e), scr_addr_i in 5 (scr_num_e), scr_wdata_i in CapWidth (write data).
REQ-008 SHALL have ports scr_asr_i in 1 (PCC holds access-system-registers permission) and pcc_i in CapWidth (current PCC).
REQ-009 SHALL have ports scr_rvalid_o out 1, scr_rdata_o out CapWidth, scr_asr_exc_o out 1, scr_illegal_o out 1.
REQ-010 SHALL have ports cheri_exc_i in 1, cheri_exc_cause_i in 5 (c_exc_cause_e), cheri_exc_reg_i in 6 (bit5=1 means SCR index).
REQ-011 SHALL have ports mccsr_we_i in 1 and mccsr_wdata_i in 32 (CSR-path write), mccsr_o out 32.
REQ-012 SHALL have ports ddc_o, mtcc_o, mepcc_o, each out CapWidth: live register values.

Function
REQ-013 SHALL sample a request when scr_req_i=1 and op != SCR_NONE; response appears exactly one cycle later with scr_rvalid_o=1 for one cycle.
REQ-014 SHALL return the pre-write value for SCR_READ and SCR_READWRITE; rdata is 0 for SCR_WRITE and for faulting requests.
REQ-015 SHALL update the target at the request edge for SCR_WRITE/SCR_READWRITE; a read issued the following cycle returns the new value.
REQ-016 SHALL treat DDC (0x01) as accessible without ASR; all other implemented SCRs except PCC require scr_asr_i=1.
REQ-017 SHALL, on ASR failure, perform no write and assert scr_asr_exc_o alongside scr_rvalid_o.
REQ-018 SHALL treat PCC (0x00) as read-only: read returns pcc_i sampled at request; any write op asserts scr_illegal_o and writes nothing.
REQ-019 SHALL treat unimplemented addresses (0x02, 0x03, other holes, U/S ranges when disabled) as illegal: scr_illegal_o=1, no write; illegal takes priority over ASR fault.
REQ-020 SHALL, when cheri_exc_i=1, load MEPCC <= pcc_i, MCCSR[9:5] <= cause, MCCSR[15:10] <= cheri_exc_reg_i, MCCSR[1] <= 1.
REQ-021 SHALL give cheri_exc_i priority over same-cycle SCR write to MEPCC and over mccsr_we_i; the losing write is dropped, and a READWRITE still returns the pre-capture value.
REQ-022 SHALL, on mccsr_we_i, write MCCSR bits [15:0] from mccsr_wdata_i, with bit0 (enable) held at 1; bits [31:16] read 0.
REQ-023 SHALL drive ddc_o/mtcc_o/mepcc_o/mccsr_o directly from registers (no combinational path from inputs).

Reset
REQ-024 SHALL on rst_ni=0 set DDC and MTCC to RootCap, all other SCRs to 0 (null), MCCSR to 32'h1.
REQ-025 SHALL on reset clear scr_rvalid_o, scr_rdata_o, scr_asr_exc_o, scr_illegal_o; a request in flight during reset produces no response.

Structure
REQ-026 SHALL take scr_op_e, scr_num_e, c_exc_cause_e from ibex_defines; new MCCSR field position constants (enable, dirty, cause, capidx) SHALL be added to ibex_defines.
REQ-027 SHALL be one module with no sub-module; U/S SCR storage SHALL be generate-guarded by ImplUScr/ImplSScr.

Verification
REQ-028 Reset, then READ DDC with asr=0 -> next cycle rvalid=1, rdata=RootCap, no fault.
REQ-029 READWRITE MSCRATCHC (0x1E) wdata=0xA5, asr=1 -> rdata=0; next-cycle READ -> rdata=0xA5.
REQ-030 WRITE MTCC (0x1C) wdata=0x10, asr=0 -> scr_asr_exc_o=1; mtcc_o stays RootCap.
REQ-031 WRITE 0x04 with ImplUScr=0, asr=1 -> scr_illegal_o=1, scr_asr_exc_o=0; WRITE 0x00 -> scr_illegal_o=1.
REQ-032 Same cycle: cheri_exc_i=1, cause=0x02, reg=0x21, pcc_i=0x80, plus SCR WRITE MEPCC=0x55 and mccsr_we_i -> mepcc_o=0x80, mccsr_o=0x0000_8443.
REQ-033 Assert rst_ni low one cycle after a READ request -> no rvalid; all registers at reset values.

Source files
------------

// File: rtl/ibex_defines.sv
// Shared Ibex CHERI definitions: SCR operation/number encodings, CHERI exception
// causes and the MCCSR field layout.
package ibex_defines;

    typedef enum logic [1:0] {
        SCR_NONE      = 2'b00,
        SCR_READ      = 2'b01,
        SCR_WRITE     = 2'b10,
        SCR_READWRITE = 2'b11
    } scr_op_e;

    typedef enum logic [4:0] {
        SCR_PCC       = 5'h00,
        SCR_DDC       = 5'h01,
        SCR_UTCC      = 5'h04,
        SCR_UTDC      = 5'h05,
        SCR_USCRATCHC = 5'h06,
        SCR_UEPCC     = 5'h07,
        SCR_STCC      = 5'h0C,
        SCR_STDC      = 5'h0D,
        SCR_SSCRATCHC = 5'h0E,
        SCR_SEPCC     = 5'h0F,
        SCR_MTCC      = 5'h1C,
        SCR_MTDC      = 5'h1D,
        SCR_MSCRATCHC = 5'h1E,
        SCR_MEPCC     = 5'h1F
    } scr_num_e;

    typedef enum logic [4:0] {
        CHERI_EXC_NONE   = 5'h00,
        CHERI_EXC_BOUNDS = 5'h01,
        CHERI_EXC_TAG    = 5'h02,
        CHERI_EXC_SEAL   = 5'h03,
        CHERI_EXC_TYPE   = 5'h04,
        CHERI_EXC_PERM_X = 5'h11,
        CHERI_EXC_PERM_L = 5'h12,
        CHERI_EXC_PERM_S = 5'h13,
        CHERI_EXC_ASR    = 5'h18
    } c_exc_cause_e;

    // MCCSR layout; only the low half is architected, the upper half reads zero.
    localparam int unsigned MCCSR_ENABLE_BIT = 0;
    localparam int unsigned MCCSR_DIRTY_BIT  = 1;
    localparam int unsigned MCCSR_CAUSE_LSB  = 5;
    localparam int unsigned MCCSR_CAUSE_MSB  = 9;
    localparam int unsigned MCCSR_CAPIDX_LSB = 10;
    localparam int unsigned MCCSR_CAPIDX_MSB = 15;
    localparam logic [31:0] MCCSR_WR_MASK    = 32'h0000_FFFF;
    localparam logic [31:0] MCCSR_RESET      = 32'h0000_0001;

endpackage

// File: rtl/ibex_cheri_scr_file_if.sv
// SCR access bus: one-cycle request from the pipeline, registered response
// (valid, data, fault flags) from the SCR file.
interface ibex_cheri_scr_file_if #(
    parameter int unsigned CapWidth = 64
);
    import ibex_defines::*;

    logic                scr_req_i;
    scr_op_e             scr_op_i;
    logic [4:0]          scr_addr_i;
    logic [CapWidth-1:0] scr_wdata_i;
    logic                scr_asr_i;

    logic                scr_rvalid_o;
    logic [CapWidth-1:0] scr_rdata_o;
    logic                scr_asr_exc_o;
    logic                scr_illegal_o;

    modport master (
        output scr_req_i, scr_op_i, scr_addr_i, scr_wdata_i, scr_asr_i,
        input  scr_rvalid_o, scr_rdata_o, scr_asr_exc_o, scr_illegal_o
    );

    modport slave (
        input  scr_req_i, scr_op_i, scr_addr_i, scr_wdata_i, scr_asr_i,
        output scr_rvalid_o, scr_rdata_o, scr_asr_exc_o, scr_illegal_o
    );

endinterface

// File: rtl/ibex_cheri_scr_file.sv
// CHERI special capability register file: DDC, M-mode SCRs, optional U/S banks,
// read-only PCC view, MCCSR, and exception capture into MEPCC/MCCSR.
module ibex_cheri_scr_file
    import ibex_defines::*;
#(
    parameter int unsigned         CapWidth = 64,
    parameter bit                  ImplUScr = 1'b0,
    parameter bit                  ImplSScr = 1'b0,
    parameter logic [CapWidth-1:0] RootCap  = '1
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    ibex_cheri_scr_file_if.slave scr,
    input  logic [CapWidth-1:0] pcc_i,

    input  logic                cheri_exc_i,
    input  c_exc_cause_e        cheri_exc_cause_i,
    input  logic [5:0]          cheri_exc_reg_i,

    input  logic                mccsr_we_i,
    input  logic [31:0]         mccsr_wdata_i,
    output logic [31:0]         mccsr_o,

    output logic [CapWidth-1:0] ddc_o,
    output logic [CapWidth-1:0] mtcc_o,
    output logic [CapWidth-1:0] mepcc_o
);

    logic [CapWidth-1:0] ddc_q, mtcc_q, mtdc_q, mscratchc_q, mepcc_q;
    logic [31:0]         mccsr_q;
    logic [CapWidth-1:0] u_rdata, s_rdata;

    logic                req_valid, op_read, op_write;
    logic                addr_impl, needs_asr;
    logic [CapWidth-1:0] cur_val;
    logic                illegal, asr_fault, do_write;

    logic                rvalid_q, asr_exc_q, illegal_q;
    logic [CapWidth-1:0] rdata_q;

    assign req_valid = scr.scr_req_i && (scr.scr_op_i != SCR_NONE);
    assign op_read   = (scr.scr_op_i == SCR_READ)  || (scr.scr_op_i == SCR_READWRITE);
    assign op_write  = (scr.scr_op_i == SCR_WRITE) || (scr.scr_op_i == SCR_READWRITE);

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        addr_impl = 1'b0;
        needs_asr = 1'b1;
        cur_val   = '0;
        case (scr.scr_addr_i)
            SCR_PCC:       begin addr_impl = 1'b1; needs_asr = 1'b0; cur_val = pcc_i; end
            SCR_DDC:       begin addr_impl = 1'b1; needs_asr = 1'b0; cur_val = ddc_q; end
            SCR_MTCC:      begin addr_impl = 1'b1; cur_val = mtcc_q;      end
            SCR_MTDC:      begin addr_impl = 1'b1; cur_val = mtdc_q;      end
            SCR_MSCRATCHC: begin addr_impl = 1'b1; cur_val = mscratchc_q; end
            SCR_MEPCC:     begin addr_impl = 1'b1; cur_val = mepcc_q;     end
            SCR_UTCC, SCR_UTDC, SCR_USCRATCHC, SCR_UEPCC:
                           begin addr_impl = ImplUScr; cur_val = u_rdata; end
            SCR_STCC, SCR_STDC, SCR_SSCRATCHC, SCR_SEPCC:
                           begin addr_impl = ImplSScr; cur_val = s_rdata; end
            default: ;
        endcase
    end

    // Illegal (hole, disabled bank, or write to PCC) masks any ASR fault.
    assign illegal   = !addr_impl || ((scr.scr_addr_i == SCR_PCC) && op_write);
    assign asr_fault = !illegal && needs_asr && !scr.scr_asr_i;
    assign do_write  = req_valid && op_write && !illegal && !asr_fault;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            asr_exc_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            rvalid_q  <= req_valid;
            asr_exc_q <= req_valid && asr_fault;
            illegal_q <= req_valid && illegal;
            rdata_q   <= (req_valid && op_read && !illegal && !asr_fault) ? cur_val : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ddc_q       <= RootCap;
            mtcc_q      <= RootCap;
            mtdc_q      <= '0;
            mscratchc_q <= '0;
            mepcc_q     <= '0;
            mccsr_q     <= MCCSR_RESET;
        end else begin
            if (do_write) begin
                case (scr.scr_addr_i)
                    SCR_DDC:       ddc_q       <= scr.scr_wdata_i;
                    SCR_MTCC:      mtcc_q      <= scr.scr_wdata_i;
                    SCR_MTDC:      mtdc_q      <= scr.scr_wdata_i;
                    SCR_MSCRATCHC: mscratchc_q <= scr.scr_wdata_i;
                    SCR_MEPCC:     mepcc_q     <= scr.scr_wdata_i;
                    default: ;
                endcase
            end
            // NOTE: the last non-blocking assignment to a register wins, so the
            // exception capture below overrides a same-cycle SCR write to MEPCC.
            if (cheri_exc_i) begin
                mepcc_q <= pcc_i;
                mccsr_q[MCCSR_CAUSE_MSB:MCCSR_CAUSE_LSB]   <= cheri_exc_cause_i;
                mccsr_q[MCCSR_CAPIDX_MSB:MCCSR_CAPIDX_LSB] <= cheri_exc_reg_i;
                mccsr_q[MCCSR_DIRTY_BIT]                   <= 1'b1;
            end else if (mccsr_we_i) begin
                mccsr_q <= (mccsr_wdata_i & MCCSR_WR_MASK) | (32'h1 << MCCSR_ENABLE_BIT);
            end
        end
    end

    // Optional banks: slot index is addr[1:0], bank selected by addr[4:2].
    if (ImplUScr) begin : g_u_scr
        logic [CapWidth-1:0] u_scr_q [4];
        // NOTE: this small array is reset like ordinary flops because every SCR must read null after reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < 4; i++) u_scr_q[i] <= '0;
            end else if (do_write && (scr.scr_addr_i[4:2] == 3'b001)) begin
                u_scr_q[scr.scr_addr_i[1:0]] <= scr.scr_wdata_i;
            end
        end
        assign u_rdata = u_scr_q[scr.scr_addr_i[1:0]];
    end else begin : g_no_u_scr
        assign u_rdata = '0;
    end

    if (ImplSScr) begin : g_s_scr
        logic [CapWidth-1:0] s_scr_q [4];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < 4; i++) s_scr_q[i] <= '0;
            end else if (do_write && (scr.scr_addr_i[4:2] == 3'b011)) begin
                s_scr_q[scr.scr_addr_i[1:0]] <= scr.scr_wdata_i;
            end
        end
        assign s_rdata = s_scr_q[scr.scr_addr_i[1:0]];
    end else begin : g_no_s_scr
        assign s_rdata = '0;
    end

    assign scr.scr_rvalid_o  = rvalid_q;
    assign scr.scr_rdata_o   = rdata_q;
    assign scr.scr_asr_exc_o = asr_exc_q;
    assign scr.scr_illegal_o = illegal_q;

    assign ddc_o   = ddc_q;
    assign mtcc_o  = mtcc_q;
    assign mepcc_o = mepcc_q;
    assign mccsr_o = mccsr_q;

endmodule

// File: tb/tb_ibex_cheri_scr_file.sv
// Scoreboard bench for ibex_cheri_scr_file: expected responses are queued when a
// request is driven and compared when rvalid appears on the following cycle.
module tb_ibex_cheri_scr_file;
    import ibex_defines::*;

    localparam int unsigned  CW   = 64;
    localparam logic [CW-1:0] ROOT = '1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [CW-1:0] pcc_i;
    logic          cheri_exc_i;
    c_exc_cause_e  cheri_exc_cause_i;
    logic [5:0]    cheri_exc_reg_i;
    logic          mccsr_we_i;
    logic [31:0]   mccsr_wdata_i;
    logic [31:0]   mccsr_o;
    logic [CW-1:0] ddc_o, mtcc_o, mepcc_o;

    ibex_cheri_scr_file_if #(.CapWidth(CW)) bus ();

    ibex_cheri_scr_file #(
        .CapWidth (CW),
        .ImplUScr (1'b0),
        .ImplSScr (1'b1),
        .RootCap  (ROOT)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .scr               (bus.slave),
        .pcc_i             (pcc_i),
        .cheri_exc_i       (cheri_exc_i),
        .cheri_exc_cause_i (cheri_exc_cause_i),
        .cheri_exc_reg_i   (cheri_exc_reg_i),
        .mccsr_we_i        (mccsr_we_i),
        .mccsr_wdata_i     (mccsr_wdata_i),
        .mccsr_o           (mccsr_o),
        .ddc_o             (ddc_o),
        .mtcc_o            (mtcc_o),
        .mepcc_o           (mepcc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string         tag;
        int            due;
        logic [CW-1:0] rdata;
        logic          asr_exc;
        logic          illegal;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // Response monitor, sampling on the falling edge.
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (bus.scr_rvalid_o) begin
            if (sb.size() == 0) begin
                check("unexp_rvalid", 64'(bus.scr_rvalid_o), 64'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_latency"}, 64'(cyc), 64'(e.due));
                check({e.tag, "_rdata"},   bus.scr_rdata_o, e.rdata);
                check({e.tag, "_asr"},     64'(bus.scr_asr_exc_o), 64'(e.asr_exc));
                check({e.tag, "_illegal"}, 64'(bus.scr_illegal_o), 64'(e.illegal));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check({e.tag, "_missing"}, 64'(bus.scr_rvalid_o), 64'd1);
        end
    end

    task automatic req(input scr_op_e op, input logic [4:0] addr, input logic [CW-1:0] wdata,
                       input logic asr, input logic [CW-1:0] e_rdata, input logic e_asr,
                       input logic e_ill, input string tag);
        exp_t e;
        @(negedge clk_i); #1;
        bus.scr_req_i   = 1'b1;
        bus.scr_op_i    = op;
        bus.scr_addr_i  = addr;
        bus.scr_wdata_i = wdata;
        bus.scr_asr_i   = asr;
        cheri_exc_i     = 1'b0;
        mccsr_we_i      = 1'b0;
        e.tag = tag; e.due = cyc + 1; e.rdata = e_rdata; e.asr_exc = e_asr; e.illegal = e_ill;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk_i); #1;
        bus.scr_req_i = 1'b0;
        bus.scr_op_i  = SCR_NONE;
        cheri_exc_i   = 1'b0;
        mccsr_we_i    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.scr_req_i = 1'b0; bus.scr_op_i = SCR_NONE; bus.scr_addr_i = '0;
        bus.scr_wdata_i = '0; bus.scr_asr_i = 1'b0;
        pcc_i = '0; cheri_exc_i = 1'b0; cheri_exc_cause_i = CHERI_EXC_NONE;
        cheri_exc_reg_i = '0; mccsr_we_i = 1'b0; mccsr_wdata_i = '0;

        repeat (3) @(negedge clk_i);
        check("rst_rvalid", 64'(bus.scr_rvalid_o), 64'd0);
        check("rst_rdata",  bus.scr_rdata_o, 64'd0);
        check("rst_ddc",    ddc_o, ROOT);
        check("rst_mtcc",   mtcc_o, ROOT);
        check("rst_mepcc",  mepcc_o, 64'd0);
        check("rst_mccsr",  64'(mccsr_o), 64'h1);
        #1 rst_ni = 1'b1;

        // Basic access and ASR gating.
        req(SCR_READ,      SCR_DDC,       0,     1'b0, ROOT,  1'b0, 1'b0, "rd_ddc_root");
        req(SCR_READWRITE, SCR_MSCRATCHC, 'hA5,  1'b1, 0,     1'b0, 1'b0, "rw_mscratch");
        req(SCR_READ,      SCR_MSCRATCHC, 0,     1'b1, 'hA5,  1'b0, 1'b0, "rd_mscratch");
        req(SCR_WRITE,     SCR_MTCC,      'h10,  1'b0, 0,     1'b1, 1'b0, "wr_mtcc_noasr");
        req(SCR_READ,      SCR_MTCC,      0,     1'b0, 0,     1'b1, 1'b0, "rd_mtcc_noasr");
        idle();
        check("mtcc_kept", mtcc_o, ROOT);

        // Illegal addresses and read-only PCC.
        req(SCR_WRITE, 5'h04,   'h1, 1'b1, 0, 1'b0, 1'b1, "wr_u_disabled");
        req(SCR_WRITE, SCR_PCC, 'h1, 1'b1, 0, 1'b0, 1'b1, "wr_pcc");
        req(SCR_READ,  5'h02,   0,   1'b0, 0, 1'b0, 1'b1, "rd_hole02_noasr");
        req(SCR_READ,  5'h10,   0,   1'b1, 0, 1'b0, 1'b1, "rd_hole10");
        req(SCR_READ,  SCR_PCC, 0,   1'b0, 'h1234, 1'b0, 1'b0, "rd_pcc");
        pcc_i = 'h1234;

        // DDC writable without ASR; other M and S registers.
        req(SCR_WRITE,     SCR_DDC,       'h77,   1'b0, 0,       1'b0, 1'b0, "wr_ddc");
        req(SCR_READ,      SCR_DDC,       0,      1'b0, 'h77,    1'b0, 1'b0, "rd_ddc");
        req(SCR_WRITE,     SCR_MTDC,      'hDEAD, 1'b1, 0,       1'b0, 1'b0, "wr_mtdc");
        req(SCR_READ,      SCR_MTDC,      0,      1'b1, 'hDEAD,  1'b0, 1'b0, "rd_mtdc");
        req(SCR_WRITE,     SCR_SSCRATCHC, 'h3C,   1'b1, 0,       1'b0, 1'b0, "wr_sscratch");
        req(SCR_READWRITE, SCR_SSCRATCHC, 'h99,   1'b1, 'h3C,    1'b0, 1'b0, "rw_sscratch");
        req(SCR_READ,      SCR_SSCRATCHC, 0,      1'b1, 'h99,    1'b0, 1'b0, "rd_sscratch");
        req(SCR_READ,      SCR_STCC,      0,      1'b0, 0,       1'b1, 1'b0, "rd_stcc_noasr");
        idle();
        check("ddc_live", ddc_o, 64'h77);

        // Exception capture beats same-cycle MEPCC write and MCCSR write.
        req(SCR_WRITE, SCR_MEPCC, 'h55, 1'b1, 0, 1'b0, 1'b0, "wr_mepcc_vs_exc");
        pcc_i = 'h80; cheri_exc_i = 1'b1; cheri_exc_cause_i = CHERI_EXC_TAG;
        cheri_exc_reg_i = 6'h21; mccsr_we_i = 1'b1; mccsr_wdata_i = 32'h0000_001C;
        idle();
        check("exc_mepcc", mepcc_o, 64'h80);
        check("exc_mccsr", 64'(mccsr_o), 64'h0000_8443);

        req(SCR_READWRITE, SCR_MEPCC, 'h66, 1'b1, 'h80, 1'b0, 1'b0, "rw_mepcc_vs_exc");
        pcc_i = 'h90; cheri_exc_i = 1'b1; cheri_exc_cause_i = CHERI_EXC_BOUNDS;
        cheri_exc_reg_i = 6'h05;
        idle();
        check("exc2_mepcc", mepcc_o, 64'h90);
        check("exc2_mccsr", 64'(mccsr_o), 64'h0000_1423);

        // CSR-path MCCSR write: upper half dropped, enable forced.
        mccsr_we_i = 1'b1; mccsr_wdata_i = 32'hABCD_1230;
        idle();
        check("mccsr_we", 64'(mccsr_o), 64'h0000_1231);

        req(SCR_WRITE, SCR_MEPCC, 'h55, 1'b1, 0,     1'b0, 1'b0, "wr_mepcc");
        req(SCR_READ,  SCR_MEPCC, 0,    1'b1, 'h55,  1'b0, 1'b0, "rd_mepcc");
        idle();
        check("mepcc_live", mepcc_o, 64'h55);

        // Reset with a READ in flight: no response, everything back to reset values.
        @(negedge clk_i); #1;
        bus.scr_req_i = 1'b1; bus.scr_op_i = SCR_READ; bus.scr_addr_i = SCR_DDC; bus.scr_asr_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        bus.scr_req_i = 1'b0; bus.scr_op_i = SCR_NONE;
        @(negedge clk_i);
        check("rst2_rvalid", 64'(bus.scr_rvalid_o), 64'd0);
        check("rst2_ddc",    ddc_o, ROOT);
        check("rst2_mtcc",   mtcc_o, ROOT);
        check("rst2_mepcc",  mepcc_o, 64'd0);
        check("rst2_mccsr",  64'(mccsr_o), 64'h1);
        #1 rst_ni = 1'b1;

        req(SCR_READ, SCR_MSCRATCHC, 0, 1'b1, 0,    1'b0, 1'b0, "rd_mscratch_rst");
        req(SCR_READ, SCR_MTDC,      0, 1'b1, 0,    1'b0, 1'b0, "rd_mtdc_rst");
        req(SCR_READ, SCR_SSCRATCHC, 0, 1'b1, 0,    1'b0, 1'b0, "rd_sscratch_rst");
        req(SCR_READ, SCR_DDC,       0, 1'b0, ROOT, 1'b0, 1'b0, "rd_ddc_rst");
        repeat (3) idle();
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
